pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter register and next-PC selector for the single-cycle core: owns PC and consumes
//  the 26-bit jump index (target = {PC+1[31:26], index}), branch offsets and call/return requests.
//  Includes a circular return-address stack (RAS) for jal/jr-style calls. Feeds instruction
//  memory address each cycle; word-addressed (PC increments by 1).
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  RAS_DEPTH     8              return-address stack entries (power of 2, >=2)
//  RAS_AW        3              log2(RAS_DEPTH), pointer width
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  stall          in   1   1 = hold PC and RAS unchanged this cycle
//  jump           in   1   take absolute jump this cycle
//  instr_index    in   26  instruction jump-index field [25:0]
//  call           in   1   with jump: push return address (PC+1) onto RAS
//  ret            in   1   pop RAS, next PC = popped address
//  branch_taken   in   1   take PC-relative branch this cycle
//  branch_offset  in   16  signed word offset, relative to PC+1
//  pc             out  32  current PC (registered)
//  pc_plus1       out  32  pc + 1, modulo 2^32 (combinational from pc)
//  ras_empty      out  1   RAS holds 0 entries
//  ras_full       out  1   RAS holds RAS_DEPTH entries
//  ras_overflow   out  1   sticky: push occurred while full
//  ras_underflow  out  1   sticky: pop occurred while empty
// BEHAVIOUR
//  - Reset (sync, highest priority): pc<=RESET_VECTOR, RAS count/pointer<=0, both sticky flags<=0.
//    After reset: ras_empty=1, ras_full=0, pc_plus1=RESET_VECTOR+1. Reset mid-call/ret discards it.
//  - All state updates on rising clk; new pc visible one cycle after request (latency 1).
//  - Next-PC priority when not stalled: ret > jump > branch_taken > sequential.
//    ret:    pc<=RAS top (empty: pc<=pc_plus1, ras_underflow<=1, count stays 0)
//    jump:   pc<={pc_plus1[31:26], instr_index}
//    branch: pc<=pc_plus1 + sign_extend32(branch_offset), modulo 2^32
//    else:   pc<=pc_plus1 (0xFFFF_FFFF wraps to 0)
//  - Push only when call=1 AND jump selected (i.e. ret=0); pushed value = pc_plus1.
//    call without jump, or call with ret, is ignored (no push).
//  - RAS is circular: top pointer increments on push, decrements on pop; count saturates.
//    Push while full: overwrite oldest slot, count stays RAS_DEPTH, ras_overflow<=1.
//    Pop while full then push: normal LIFO order preserved for the surviving entries.
//  - stall=1: pc, RAS contents, pointer, count and flags all hold; all requests dropped.
//  - Sticky flags clear only on reset. ras_empty/ras_full decode from count (registered state).
// TESTING
//  1 reset=1 one cycle -> pc=0, pc_plus1=1, ras_empty=1; 3 idle cycles -> pc=1,2,3
//  2 pc=0x0400_0010, jump, index=0x0000ABC -> next pc=0x0400_0ABC
//  3 pc=0x100, branch_taken, offset=-4 -> pc=0x0FD; offset=+0x7FFF -> pc=0x101+0x7FFF
//  4 pc=0x20 jump+call index=0x80 -> pc=0x80, RAS=1; later ret -> pc=0x21, ras_empty=1
//  5 9 jump+call pushes (DEPTH 8) -> ras_full, ras_overflow=1; 8 rets return newest 8 in LIFO
//    order; 9th ret -> pc=pc_plus1, ras_underflow=1
//  6 stall=1 with jump+call asserted -> pc and RAS unchanged; ret+jump together -> ret wins, no push

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register and next-PC selector with a circular
// return-address stack (RAS). Word-addressed, the PC advances by 1 per instruction.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold all state and drop every request this cycle
//   jump, instr_index absolute jump to {pc_plus1[31:26], instr_index}
//   call              together with a selected jump, push pc_plus1 onto the RAS
//   ret               pop the RAS; the next PC is the popped address
//   branch_taken,
//   branch_offset     PC-relative branch by a signed word offset from pc_plus1
//   pc                current PC (registered)
//   pc_plus1          pc + 1 (combinational from pc)
//   ras_empty/full    decoded from the registered entry count
//   ras_overflow      sticky: a push happened while the stack was full
//   ras_underflow     sticky: a pop happened while the stack was empty
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned RAS_DEPTH    = 8,
  parameter int unsigned RAS_AW       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        call,
  input  logic        ret,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic [31:0] pc,
  output logic [31:0] pc_plus1,
  output logic        ras_empty,
  output logic        ras_full,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  // Count needs one extra bit to represent RAS_DEPTH itself.
  localparam int unsigned CW = RAS_AW + 1;

  logic [31:0]       ras_mem [RAS_DEPTH];
  logic [RAS_AW-1:0] ptr_q;      // next free slot; top of stack is ptr_q - 1
  logic [CW-1:0]     cnt_q;
  logic [RAS_AW-1:0] top_idx;
  logic [31:0]       ras_top;

  logic [31:0]       pc_d;
  logic [RAS_AW-1:0] ptr_d;
  logic [CW-1:0]     cnt_d;
  logic              ovf_d;
  logic              unf_d;
  logic              push;

  assign pc_plus1  = pc + 32'd1;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
  assign top_idx   = ptr_q - RAS_AW'(1);
  assign ras_top   = ras_mem[top_idx];

  // Next-PC select (ret > jump > branch > sequential) and RAS bookkeeping.
  always_comb begin
    pc_d  = pc;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ras_overflow;
    unf_d = ras_underflow;
    push  = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (ras_empty) begin
          pc_d  = pc_plus1;
          unf_d = 1'b1;
        end else begin
          pc_d  = ras_top;
          ptr_d = top_idx;
          cnt_d = cnt_q - CW'(1);
        end
      end else if (jump) begin
        pc_d = {pc_plus1[31:26], instr_index};
        if (call) begin
          // When full the pointer still advances, overwriting the oldest slot.
          push  = 1'b1;
          ptr_d = ptr_q + RAS_AW'(1);
          if (ras_full) ovf_d = 1'b1;
          else          cnt_d = cnt_q + CW'(1);
        end
      end else if (branch_taken) begin
        pc_d = pc_plus1 + {{16{branch_offset[15]}}, branch_offset};
      end else begin
        pc_d = pc_plus1;
      end
    end
  end

  // PC, pointer, count and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      ptr_q         <= '0;
      cnt_q         <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      ras_overflow  <= ovf_d;
      ras_underflow <= unf_d;
    end
  end

  // Stack storage needs no reset: the count marks which slots are valid.
  always_ff @(posedge clk) begin
    if (!reset && push) ras_mem[ptr_q] <= pc_plus1;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. A second instance with a
// non-zero reset vector exercises the upper-bit merge of absolute jumps.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        stall, jump, call, ret, branch_taken;
  logic [25:0] instr_index;
  logic [15:0] branch_offset;

  logic [31:0] pc, pc_plus1, pc2, pc2_plus1;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;
  logic        e2, f2, o2, u2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .instr_index(instr_index),
    .call(call), .ret(ret), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc), .pc_plus1(pc_plus1), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  pc_sequencer #(.RESET_VECTOR(32'h0400_000F)) dut2 (
    .clk(clk), .reset(reset2), .stall(stall), .jump(jump), .instr_index(instr_index),
    .call(call), .ret(ret), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc2), .pc_plus1(pc2_plus1), .ras_empty(e2), .ras_full(f2),
    .ras_overflow(o2), .ras_underflow(u2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; jump = 0; call = 0; ret = 0; branch_taken = 0;
    instr_index = '0; branch_offset = '0;
  endtask

  task automatic do_jump(input logic [25:0] idx, input logic c);
    idle_inputs();
    jump = 1; call = c; instr_index = idx;
    tick();
    idle_inputs();
  endtask

  task automatic do_ret();
    idle_inputs();
    ret = 1;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1; reset2 = 1;
    @(negedge clk);
    tick();
    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus1", pc_plus1, 32'h1);
    chk("rst_empty", 32'(ras_empty), 32'h1);
    chk("rst_full", 32'(ras_full), 32'h0);
    chk("rst_ovf", 32'(ras_overflow), 32'h0);
    chk("rst_unf", 32'(ras_underflow), 32'h0);
    chk("rst_pc2", pc2, 32'h0400_000F);

    // Second instance: sequential then jump keeps pc_plus1[31:26]
    reset2 = 0;
    tick();
    chk("pc2_seq", pc2, 32'h0400_0010);
    jump = 1; instr_index = 26'h0000ABC;
    tick();
    chk("pc2_jump", pc2, 32'h0400_0ABC);
    chk("rst_wins_jump", pc, 32'h0);
    idle_inputs();
    reset2 = 1;

    // Sequential advance
    reset = 0;
    tick(); chk("seq1", pc, 32'h1);
    tick(); chk("seq2", pc, 32'h2);
    tick(); chk("seq3", pc, 32'h3);

    // Branches relative to pc+1
    do_jump(26'h100, 0);
    chk("jump_100", pc, 32'h100);
    branch_taken = 1; branch_offset = 16'hFFFC;
    tick(); idle_inputs();
    chk("branch_neg", pc, 32'h0FD);
    do_jump(26'h100, 0);
    branch_taken = 1; branch_offset = 16'h7FFF;
    tick(); idle_inputs();
    chk("branch_maxpos", pc, 32'h0000_8100);
    do_jump(26'h0, 0);
    branch_taken = 1; branch_offset = 16'hFFFE;
    tick(); idle_inputs();
    chk("branch_wrap", pc, 32'hFFFF_FFFF);
    tick();
    chk("seq_wrap", pc, 32'h0);

    // Call then return
    do_jump(26'h20, 0);
    do_jump(26'h80, 1);
    chk("call_pc", pc, 32'h80);
    chk("call_nonempty", 32'(ras_empty), 32'h0);
    tick();
    chk("after_call_seq", pc, 32'h81);
    do_ret();
    chk("ret_pc", pc, 32'h21);
    chk("ret_empty", 32'(ras_empty), 32'h1);

    // Stall holds everything
    stall = 1; jump = 1; call = 1; instr_index = 26'h300;
    tick(); idle_inputs();
    chk("stall_pc", pc, 32'h21);
    chk("stall_empty", 32'(ras_empty), 32'h1);

    // ret wins over jump+call and does not push
    do_jump(26'h40, 1);
    chk("call2_pc", pc, 32'h40);
    ret = 1; jump = 1; call = 1; instr_index = 26'h300;
    tick(); idle_inputs();
    chk("ret_prio_pc", pc, 32'h22);
    chk("ret_prio_empty", 32'(ras_empty), 32'h1);
    chk("ret_prio_unf", 32'(ras_underflow), 32'h0);

    // call without jump is ignored
    call = 1;
    tick(); idle_inputs();
    chk("call_only_pc", pc, 32'h23);
    chk("call_only_empty", 32'(ras_empty), 32'h1);

    // Nine pushes into an 8-deep stack: pushed 0x24, 0x1001, 0x1011 ... 0x1071
    for (int i = 0; i < 8; i++) do_jump(26'(32'h1000 + i * 32'h10), 1);
    chk("full8", 32'(ras_full), 32'h1);
    chk("ovf8", 32'(ras_overflow), 32'h0);
    do_jump(26'h1080, 1);
    chk("push9_pc", pc, 32'h1080);
    chk("full9", 32'(ras_full), 32'h1);
    chk("ovf9", 32'(ras_overflow), 32'h1);

    // Eight pops return the newest eight in LIFO order
    for (int i = 7; i >= 0; i--) begin
      do_ret();
      chk($sformatf("lifo%0d", i), pc, 32'h1001 + 32'(i) * 32'h10);
    end
    chk("lifo_empty", 32'(ras_empty), 32'h1);
    chk("lifo_unf", 32'(ras_underflow), 32'h0);
    do_ret();
    chk("underflow_pc", pc, 32'h1002);
    chk("underflow_flag", 32'(ras_underflow), 32'h1);
    chk("overflow_sticky", 32'(ras_overflow), 32'h1);

    // Only reset clears the sticky flags
    reset = 1;
    tick();
    reset = 0;
    chk("clr_ovf", 32'(ras_overflow), 32'h0);
    chk("clr_unf", 32'(ras_underflow), 32'h0);
    chk("clr_pc", pc, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
